// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and the
// zero-means-one clamp applied to the width/gap request values.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  // A programmed length of 0 behaves as 1 so every pulse and gap is visible.
  function automatic int unsigned clamp_min1(input int unsigned x);
    return (x == 0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle of pulse_train_gen. The done strobe exists only when
// PULSE_TRAIN_DONE_EN is defined.
interface pulse_train_gen_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 3
);

  logic              trig;
  logic [CNT_W-1:0]  width;
  logic [CNT_W-1:0]  gap;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
`ifdef PULSE_TRAIN_DONE_EN
  logic              done;
`endif

  modport master (
    output trig, width, gap,
    input  out, busy, pending, overflow
`ifdef PULSE_TRAIN_DONE_EN
    , input done
`endif
  );

  modport slave (
    input  trig, width, gap,
    output out, busy, pending, overflow
`ifdef PULSE_TRAIN_DONE_EN
    , output done
`endif
  );

endinterface

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the HIGH and GAP phases; holds at zero
// instead of wrapping.
module pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Turns single-cycle trig strobes into timed level pulses with a saturating
// request queue. Define PULSE_TRAIN_DONE_EN to add the end-of-gap done strobe.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PEND_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_gen_if.slave bus
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);

  state_e            state;
  logic [CNT_W-1:0]  g_lat;
  logic [PEND_W-1:0] pend;
  logic              out_q;
  logic              busy_q;
  logic              ovf_q;

  logic              t_load;
  logic [CNT_W-1:0]  t_val;
  logic              t_zero;
  logic              t_one;

  logic [CNT_W-1:0]  w_m1;
  logic [CNT_W-1:0]  g_in;
  logic              high_end;
  logic              gap_end;
  logic              deq;
  logic              direct;
  logic              enq;
  logic              start;
  logic              full;

  assign w_m1 = CNT_W'(clamp_min1(32'(bus.width)) - 32'd1);
  assign g_in = CNT_W'(clamp_min1(32'(bus.gap)));

  assign high_end = (state == HIGH) && t_zero;
  assign gap_end  = (state == GAP)  && t_zero;
  assign full     = (pend == PEND_W'(PEND_MAX));

  // A trig landing exactly on a gap end with nothing queued starts the next
  // pulse directly, just as it would from IDLE.
  assign deq    = gap_end && (pend != '0);
  assign direct = bus.trig && ((state == IDLE) || (gap_end && (pend == '0)));
  assign enq    = bus.trig && !direct;
  assign start  = direct || deq;

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    t_load = 1'b0;
    t_val  = w_m1;
    if (high_end) begin
      t_load = 1'b1;
      t_val  = g_lat - 1'b1;
    end else if (start) begin
      t_load = 1'b1;
    end
  end

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .tick     (state != IDLE),
    .zero     (t_zero),
    .one      (t_one)
  );

  // NOTE: reset is synchronous and active-low; it also discards queued requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      g_lat  <= '0;
      pend   <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= HIGH;
            out_q  <= 1'b1;
            busy_q <= 1'b1;
            g_lat  <= g_in;
          end
        end
        HIGH: begin
          if (t_zero) begin
            state <= GAP;
            out_q <= 1'b0;
          end
        end
        GAP: begin
          if (t_zero) begin
            if (start) begin
              state <= HIGH;
              out_q <= 1'b1;
              g_lat <= g_in;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          out_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase

      if (enq && !deq) begin
        if (full) ovf_q <= 1'b1;
        else      pend  <= pend + 1'b1;
      end else if (deq && !enq) begin
        pend <= pend - 1'b1;
      end
    end
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend;
  assign bus.overflow = ovf_q;

`ifdef PULSE_TRAIN_DONE_EN
  logic done_q;

  // Asserted on the edge that enters the final gap cycle.
  always_ff @(posedge clk) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= (high_end && g_lat == CNT_W'(1)) ||
                        ((state == GAP) && !t_zero && t_one);
  end

  assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: time-based reference model compared
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_pulse_train_gen;

  localparam int CNT_W    = 8;
  localparam int PEND_MAX = 4;
  localparam int PEND_W   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_train_gen_if #(.CNT_W(CNT_W), .PEND_W(PEND_W)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W), .PEND_MAX(PEND_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each pulse is a start cycle s with latched w and g; the
  // line is high on cycles s..s+w-1 and the next pulse may start at s+w+g.
  int cyc = 0;
  bit m_active = 0;
  int m_s, m_w, m_g;
  int m_pend = 0;
  bit m_ovf = 0;
  int m_starts = 0;
  int m_ovf_cnt = 0;
  bit e_out, e_busy, e_done;

  always @(posedge clk) begin
    bit took;
    cyc++;
    m_ovf = 0;
    took  = 0;
    if (!rst) begin
      m_active = 0;
      m_pend   = 0;
    end else begin
      if (m_active && cyc == m_s + m_w + m_g) m_active = 0;
      if (!m_active && (m_pend > 0 || bus.trig)) begin
        if (m_pend > 0) m_pend--;
        else            took = 1;
        m_s = cyc;
        m_w = (bus.width == 0) ? 1 : int'(bus.width);
        m_g = (bus.gap == 0) ? 1 : int'(bus.gap);
        m_active = 1;
        m_starts++;
      end
      if (bus.trig && !took) begin
        if (m_pend < PEND_MAX) m_pend++;
        else begin
          m_ovf = 1;
          m_ovf_cnt++;
        end
      end
    end
    e_out  = m_active && cyc < m_s + m_w;
    e_busy = m_active;
    e_done = m_active && cyc == m_s + m_w + m_g - 1;
  end

  always @(negedge clk) begin
    check("out", int'(bus.out), int'(e_out));
    check("busy", int'(bus.busy), int'(e_busy));
    check("pending", int'(bus.pending), m_pend);
    check("overflow", int'(bus.overflow), int'(m_ovf));
`ifdef PULSE_TRAIN_DONE_EN
    check("done", int'(bus.done), int'(e_done));
`endif
  end

  // Observed edge/strobe counts, updated just after each active edge.
  int pe = 0, ne = 0, ovf_seen = 0, done_seen = 0;
  bit prev_out = 0;
  always @(posedge clk) begin
    #1;
    if (bus.out === 1'b1 && !prev_out) pe++;
    if (bus.out === 1'b0 && prev_out)  ne++;
    prev_out = (bus.out === 1'b1);
    if (bus.overflow === 1'b1) ovf_seen++;
`ifdef PULSE_TRAIN_DONE_EN
    if (bus.done === 1'b1) done_seen++;
`endif
  end

  task automatic idle_cycles(input int n);
    bus.trig = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0] x1_out, x1_busy;
    logic [2:0] x2_out, x2_busy;
    logic [9:0] x3_out;
    int peak, pe0, ovf0, done0;

    rst       = 1'b0;
    bus.trig  = 1'b0;
    bus.width = '0;
    bus.gap   = '0;
    repeat (3) @(negedge clk);
    check("reset_out", int'(bus.out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_pending", int'(bus.pending), 0);
    rst = 1'b1;
    idle_cycles(2);

    // width=3 gap=2 single request
    bus.width = 8'd3; bus.gap = 8'd2; bus.trig = 1'b1;
    x1_out  = 6'b000111;
    x1_busy = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.trig = 1'b0;
      check("t1_out", int'(bus.out), int'(x1_out[i]));
      check("t1_busy", int'(bus.busy), int'(x1_busy[i]));
      check("t1_model_out", int'(e_out), int'(x1_out[i]));
      check("t1_model_busy", int'(e_busy), int'(x1_busy[i]));
    end
    idle_cycles(2);

    // width=0 gap=0 clamps to 1/1
    bus.width = 8'd0; bus.gap = 8'd0; bus.trig = 1'b1;
    x2_out  = 3'b001;
    x2_busy = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.trig = 1'b0;
      check("t2_out", int'(bus.out), int'(x2_out[i]));
      check("t2_busy", int'(bus.busy), int'(x2_busy[i]));
      check("t2_model_out", int'(e_out), int'(x2_out[i]));
    end
    idle_cycles(2);

    // three consecutive requests, width=2 gap=1
    bus.width = 8'd2; bus.gap = 8'd1; bus.trig = 1'b1;
    x3_out = 10'b0011011011;
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) bus.trig = 1'b0;
      if (int'(bus.pending) > peak) peak = int'(bus.pending);
      check("t3_out", int'(bus.out), int'(x3_out[i]));
    end
    check("t3_pending_peak", peak, 2);
    idle_cycles(2);

    // queue saturation: width=10, six requests during HIGH
    #2 pe0 = pe; ovf0 = ovf_seen;
    bus.width = 8'd10; bus.gap = 8'd1; bus.trig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.trig = (i < 6);
    end
    check("t4_pending_full", int'(bus.pending), PEND_MAX);
    #2 check("t4_overflows", ovf_seen - ovf0, 2);
    idle_cycles(60);
    #2 check("t4_pulses", pe - pe0, 5);
    check("t4_idle", int'(bus.busy), 0);

    // reset during HIGH with two queued requests
    bus.width = 8'd10; bus.gap = 8'd3; bus.trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.trig = 1'b0;
        rst = 1'b0;
      end
    end
    check("t5_pending_before", int'(bus.pending), 2);
    @(negedge clk);
    rst = 1'b1;
    check("t5_out", int'(bus.out), 0);
    check("t5_busy", int'(bus.busy), 0);
    check("t5_pending", int'(bus.pending), 0);
    #2 pe0 = pe;
    idle_cycles(30);
    #2 check("t5_no_more_pulses", pe - pe0, 0);

    // eight randomly spaced requests: one edge of each polarity per request
    #2 pe0 = pe; done0 = done_seen;
    for (int k = 0; k < 8; k++) begin
      bus.width = 8'($urandom_range(0, 5));
      bus.gap   = 8'($urandom_range(0, 4));
      bus.trig  = 1'b1;
      @(negedge clk);
      bus.trig  = 1'b0;
      repeat ($urandom_range(12, 20)) @(negedge clk);
    end
    #2 check("t6_pedges", pe - pe0, 8);
`ifdef PULSE_TRAIN_DONE_EN
    check("t6_done", done_seen - done0, 8);
`endif

    // random traffic with changing width/gap and occasional reset
    for (int k = 0; k < 600; k++) begin
      bus.trig  = ($urandom_range(0, 4) == 0);
      bus.width = 8'($urandom_range(0, 6));
      bus.gap   = 8'($urandom_range(0, 4));
      rst       = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    idle_cycles(80);
    #2;
    check("final_pedges", pe, m_starts);
    check("final_nedges", ne, pe);
    check("final_overflows", ovf_seen, m_ovf_cnt);
    check("final_idle", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
